// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES round scheduler: block and round
// counter widths, the scheduler state encoding and the round-count helper.
package aes_pkg;

    localparam int BLK_W   = 128;
    localparam int ROUND_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } sched_state_t;

    // Number of full rounds for key-size select x (0: AES-128 .. 2: AES-256).
    function automatic int nr(input int x);
        return 10 + 2 * x;
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin arbiter. Purely combinational; the priority pointer rr
// is owned by the caller and names the requester that wins a tie.
module aes_rr_arbiter (
    input  logic [0:1] req,
    input  logic       rr,
    input  logic       en,
    output logic [0:1] gnt,
    output logic       gnt_id
);

    // Pick the winner: a lone requester always wins, a tie goes to rr.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        gnt_id = 1'b0;
        gnt    = 2'b00;
        if (req[0] && req[1]) begin
            gnt_id = rr;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
        if (en) begin
            gnt[0] = req[0] && !(req[1] && rr);
            gnt[1] = req[1] && !(req[0] && !rr);
        end
    end

endmodule

// File: rtl/aes_round_scheduler.sv
// Shares one external single-cycle AES round datapath between two requesters.
// Accepts a block, applies the initial AddRoundKey, feeds Nr rounds through
// the datapath with the matching round key, then holds the ciphertext with
// its owner ID until the consumer takes it.
module aes_round_scheduler
    import aes_pkg::*;
#(
    parameter int x = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [0:1]                  req_valid,
    input  logic [0:2*BLK_W-1]          req_data,
    output logic [0:1]                  req_ready,
    input  logic [0:BLK_W*(11+2*x)-1]   words,
    output logic [0:BLK_W-1]            dp_in,
    output logic [0:BLK_W-1]            dp_key,
    output logic                        dp_final,
    input  logic [0:BLK_W-1]            dp_out,
    output logic                        out_valid,
    output logic [0:BLK_W-1]            out_data,
    output logic                        out_id,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int                 NKEYS = nr(x) + 1;
    localparam logic [ROUND_W-1:0] NR_R  = ROUND_W'(nr(x));

    sched_state_t        fsm_q;
    logic [0:BLK_W-1]    state_q;
    logic [ROUND_W-1:0]  round_q;
    logic                id_q;
    logic                rr_q;

    logic [0:1]          gnt;
    logic                gnt_id;
    logic                arb_en;
    logic [0:BLK_W-1]    req_sel;
    logic [0:BLK_W-1]    rkey [NKEYS];

    // Split the expanded key bus into one entry per round key.
    for (genvar r = 0; r < NKEYS; r++) begin : g_key
        assign rkey[r] = words[r*BLK_W +: BLK_W];
    end

    // Grants are only offered in IDLE and never while reset is asserted.
    assign arb_en = (fsm_q == IDLE) && !reset;

    aes_rr_arbiter u_arb (
        .req    (req_valid),
        .rr     (rr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    assign req_sel   = gnt_id ? req_data[BLK_W:2*BLK_W-1] : req_data[0:BLK_W-1];

    // Accept, iterate rounds through the datapath, then hold the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
            id_q    <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            case (fsm_q)
                IDLE: begin
                    if (|gnt) begin
                        state_q <= req_sel ^ rkey[0];
                        round_q <= ROUND_W'(1);
                        id_q    <= gnt_id;
                        rr_q    <= ~gnt_id;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= dp_out;
                    if (round_q < NR_R) begin
                        round_q <= round_q + ROUND_W'(1);
                    end else begin
                        fsm_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        fsm_q <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    // Drive the datapath only while a round is in progress.
    always_comb begin
        dp_in    = '0;
        dp_key   = '0;
        dp_final = 1'b0;
        if (fsm_q == ROUND && round_q <= NR_R) begin
            dp_in    = state_q;
            dp_key   = rkey[round_q];
            dp_final = (round_q == NR_R);
        end
    end

    assign out_valid = (fsm_q == HOLD);
    assign out_data  = out_valid ? state_q : '0;
    assign out_id    = out_valid && id_q;
    assign busy      = (fsm_q != IDLE);

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: an AES-128 and an AES-256 scheduler share
// the same requester/consumer stimulus, each with its own bench-side round
// datapath and key schedule. A transaction-level AES model predicts every
// output on every cycle; FIPS-197 vectors pin the model and the DUT.
module tb_aes_round_scheduler;

    localparam int NR0 = 10;
    localparam int NR1 = 14;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2    = 128'hdeadbeef0123456789abcdeff0e1d2c3;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] RK10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [0:1]     req_valid = 2'b00;
    logic [0:255]   req_data = '0;
    logic           out_ready = 1'b0;
    logic [0:1407]  words0 = '0;
    logic [0:1919]  words1 = '0;

    logic [0:1]     rdy0, rdy1;
    logic [127:0]   dpin0, dpkey0, dpout0, od0;
    logic [127:0]   dpin1, dpkey1, dpout1, od1;
    logic           df0, ov0, oi0, busy0;
    logic           df1, ov1, oi1, busy1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rst_cnt = 0;
    int rst_seen = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk [2][15];

    // Model state per instance: age < 0 idle, else cycles since accept.
    int           age [2] = '{-1, -1};
    logic         id_m [2] = '{1'b0, 1'b0};
    logic         rr_m [2] = '{1'b0, 1'b0};
    logic [127:0] trace [2][15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge reset) rst_cnt <= rst_cnt + 1;

    aes_round_scheduler #(.x(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy0), .words(words0), .dp_in(dpin0), .dp_key(dpkey0),
        .dp_final(df0), .dp_out(dpout0), .out_valid(ov0), .out_data(od0),
        .out_id(oi0), .out_ready(out_ready), .busy(busy0)
    );

    aes_round_scheduler #(.x(2)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy1), .words(words1), .dp_in(dpin1), .dp_key(dpkey1),
        .dp_final(df1), .dp_out(dpout1), .out_valid(ov1), .out_data(od1),
        .out_id(oi1), .out_ready(out_ready), .busy(busy1)
    );

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, aa, bb;
        r = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) r = r ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return r;
    endfunction

    // S-box from the field inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] p, inv;
        p = a; inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // One full round: SubBytes, ShiftRows, MixColumns (unless final), AddRoundKey.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r + 4*((c+r) % 4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    task automatic expand(input int k, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int          n;
        n = nk + 6; rc = 8'h01;
        for (int i = 0; i < 4*(n+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                tmp = w[i-1];
                if (i % nk == 0) begin
                    tmp = subw({tmp[23:0], tmp[31:24]});
                    tmp[31:24] = tmp[31:24] ^ rc;
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    tmp = subw(tmp);
                end
                w[i] = w[i-nk] ^ tmp;
            end
        end
        for (int r = 0; r < 15; r++)
            rk[k][r] = (r <= n) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] encrypt(input int k, input logic [127:0] pt);
        logic [127:0] s;
        int n;
        n = (k == 0) ? NR0 : NR1;
        s = pt ^ rk[k][0];
        for (int r = 1; r <= n; r++) s = aes_round(s, rk[k][r], r == n);
        return s;
    endfunction

    // Bench-side combinational round datapaths.
    assign dpout0 = aes_round(dpin0, dpkey0, df0);
    assign dpout1 = aes_round(dpin1, dpkey1, df1);

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int winner(input logic [0:1] v, input logic rr);
        if (v[0] && v[1]) return rr ? 1 : 0;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    task automatic model_cycle(input int k, input logic [0:1] rdy, input logic bsy,
                               input logic ov, input logic [127:0] od, input logic oi,
                               input logic [127:0] di, input logic [127:0] dk, input logic df);
        int n, g;
        logic [0:1] e_rdy;
        logic e_bsy, e_ov, e_oi, e_df;
        logic [127:0] e_od, e_di, e_dk, pt;
        string p;
        n = (k == 0) ? NR0 : NR1;
        p = $sformatf("i%0d_c%0d_", k, cyc);
        e_rdy = 2'b00; e_bsy = 1'b0; e_ov = 1'b0; e_oi = 1'b0; e_df = 1'b0;
        e_od = '0; e_di = '0; e_dk = '0; g = -1;
        if (!reset) begin
            if (age[k] < 0) begin
                g = winner(req_valid, rr_m[k]);
                if (g >= 0) e_rdy[g] = 1'b1;
            end else if (age[k] < n) begin
                e_bsy = 1'b1;
                e_di  = trace[k][age[k]];
                e_dk  = rk[k][age[k]+1];
                e_df  = (age[k] + 1 == n);
            end else begin
                e_bsy = 1'b1; e_ov = 1'b1;
                e_od  = trace[k][n];
                e_oi  = id_m[k];
            end
        end
        check({p, "req_ready"}, 128'(rdy), 128'(e_rdy));
        check({p, "busy"},      128'(bsy), 128'(e_bsy));
        check({p, "out_valid"}, 128'(ov),  128'(e_ov));
        check({p, "out_data"},  od, e_od);
        check({p, "out_id"},    128'(oi),  128'(e_oi));
        check({p, "dp_in"},     di, e_di);
        check({p, "dp_key"},    dk, e_dk);
        check({p, "dp_final"},  128'(df),  128'(e_df));
        // Advance to the state after the coming rising edge.
        if (reset) begin
            age[k] = -1; rr_m[k] = 1'b0;
        end else if (age[k] < 0) begin
            if (g >= 0) begin
                pt = (g == 1) ? req_data[128:255] : req_data[0:127];
                age[k] = 0; id_m[k] = (g == 1); rr_m[k] = (g == 0);
                trace[k][0] = pt ^ rk[k][0];
                for (int r = 1; r <= n; r++)
                    trace[k][r] = aes_round(trace[k][r-1], rk[k][r], r == n);
            end
        end else if (age[k] < n) begin
            age[k]++;
        end else if (out_ready) begin
            age[k] = -1;
        end
    endtask

    // Per-cycle comparison of both schedulers against the model.
    always @(negedge clk) begin
        if (rst_cnt != rst_seen) begin
            rst_seen = rst_cnt;
            for (int k = 0; k < 2; k++) begin age[k] = -1; rr_m[k] = 1'b0; end
        end
        model_cycle(0, rdy0, busy0, ov0, od0, oi0, dpin0, dpkey0, df0);
        model_cycle(1, rdy1, busy1, ov1, od1, oi1, dpin1, dpkey1, df1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        step(); reset = 1'b1;
        step(); reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 128'({rdy0, rdy1, busy0, busy1, ov0, ov1, oi0, oi1, df0, df1}), 128'h0);
        check({tag, "_data"}, od0 | od1 | dpin0 | dpin1 | dpkey0 | dpkey1, 128'h0);
    endtask

    task automatic wait_ov0(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = ov0;
        end
        check({tag, "_reach_out_valid"}, 128'(found), 128'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int lat [2];
        logic [127:0] ct [2];
        logic id_seen [2];
        int gid [$];
        int gcyc [$];
        logic [127:0] hd;
        logic found;

        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        expand(0, {K128, 128'h0}, 4);
        expand(1, K256, 8);
        for (int r = 0; r < 11; r++) words0[128*r +: 128] = rk[0][r];
        for (int r = 0; r < 15; r++) words1[128*r +: 128] = rk[1][r];

        // Literal pins on the model itself.
        check("model_rk10_aes128", rk[0][10], RK10);
        check("model_ct_aes128", encrypt(0, PT), CT128);
        check("model_ct_aes256", encrypt(1, PT), CT256);

        @(posedge clk); #1;
        check_all_zero("reset_state");

        // Known-answer blocks on both key sizes with latency measurement.
        step(); reset = 1'b0; req_valid = 2'b10; req_data = {PT, PT2}; out_ready = 1'b1;
        @(posedge clk); #1; acc = cyc; #1; req_valid = 2'b00;
        lat = '{-1, -1};
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ov0 && lat[0] < 0) begin lat[0] = cyc - acc; ct[0] = od0; id_seen[0] = oi0; end
            if (ov1 && lat[1] < 0) begin lat[1] = cyc - acc; ct[1] = od1; id_seen[1] = oi1; end
        end
        check("kat128_latency", 128'(lat[0]), 128'(10));
        check("kat128_data", ct[0], CT128);
        check("kat128_id", 128'(id_seen[0]), 128'h0);
        check("kat256_latency", 128'(lat[1]), 128'(14));
        check("kat256_data", ct[1], CT256);

        // Contention: both requesters held valid, consumer always ready.
        reset_pulse(); req_valid = 2'b11; req_data = {PT, PT2}; out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rdy0 != 2'b00) begin gid.push_back(rdy0[1] ? 1 : 0); gcyc.push_back(cyc); end
        end
        check("contention_grant_count_ge4", 128'(gid.size() >= 4), 128'h1);
        for (int i = 0; i < 4 && i < gid.size(); i++)
            check($sformatf("contention_grant%0d", i), 128'(gid[i]), 128'(i % 2));
        for (int i = 1; i < 4 && i < gcyc.size(); i++)
            check($sformatf("contention_period%0d", i), 128'(gcyc[i] - gcyc[i-1]), 128'(NR0 + 2));

        // Backpressure: hold out_ready low for 5 cycles in HOLD.
        step(); req_valid = 2'b10; out_ready = 1'b0;
        wait_ov0("bp");
        hd = od0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", i), 128'(ov0), 128'h1);
            check($sformatf("bp_data%0d", i), od0, hd);
            check($sformatf("bp_ready%0d", i), 128'(rdy0), 128'h0);
        end
        step(); out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_busy", 128'(busy0), 128'h0);
        check("bp_idle_valid", 128'(ov0), 128'h0);
        check("bp_idle_ready", 128'(rdy0), 128'(2'b10));
        #1; req_valid = 2'b00;

        // Reset asserted asynchronously during round 4.
        reset_pulse(); req_valid = 2'b10; req_data = {PT, PT2}; out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = busy0 && (dpkey0 == rk[0][4]);
        end
        check("rst_mid_reach_round4", 128'(found), 128'h1);
        #1; reset = 1'b1;
        #1; check_all_zero("rst_mid_immediate");
        step(); reset = 1'b0; req_valid = 2'b11;
        @(negedge clk);
        check("rst_mid_first_grant", 128'(rdy0), 128'(2'b10));
        wait_ov0("rst_mid");
        check("rst_mid_data", od0, CT128);
        check("rst_mid_id", 128'(oi0), 128'h0);

        // Lone requester 1 right after reset (rr = 0).
        reset_pulse(); req_valid = 2'b01; req_data = {PT2, PT};
        @(negedge clk);
        check("lone1_grant_i0", 128'(rdy0), 128'(2'b01));
        check("lone1_grant_i1", 128'(rdy1), 128'(2'b01));
        wait_ov0("lone1");
        check("lone1_data", od0, CT128);
        check("lone1_id", 128'(oi0), 128'h1);

        // Randomized traffic with occasional resets and backpressure.
        for (int i = 0; i < 3000; i++) begin
            step();
            reset     = ($urandom_range(0, 299) == 0);
            req_valid = 2'($urandom);
            req_data  = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
        end
        step(); reset = 1'b0; req_valid = 2'b00;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_scheduler.md
# aes_round_scheduler

Controller that shares one iterative AES round datapath between two requesters. It arbitrates round-robin between the requesters, runs the initial AddRoundKey itself, and then sequences Nr = 10+2·x rounds through the external round datapath, selecting the matching round key from the expanded key bus for each round. It returns the ciphertext with the requester ID over a valid/ready output port. It sits between the key expander (supplies `words`) and the shared `sub_bytes`/`shift_rows`/`MixColumns`/`add_round_key` round logic.

## Interface
- `x`, default 0; key-size select: 0 = AES-128, 1 = AES-192, 2 = AES-256; Nr = 10+2·x.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  [0:1]  per-requester block valid.
- `req_data`  in  [0:255]  requester 0 at [0:127], requester 1 at [128:255]; bit 0 is the MSB of byte 0.
- `req_ready`  out  [0:1]  per-requester accept (grant).
- `words`  in  [0:128·(11+2·x)-1]  expanded round keys; key r at [128·r +: 128]; stable while busy.
- `dp_in`  out  [0:127]  state presented to the round datapath.
- `dp_key`  out  [0:127]  round key for the current round.
- `dp_final`  out  1  when 1, the datapath bypasses MixColumns.
- `dp_out`  in  [0:127]  combinational round result from the datapath.
- `out_valid`  out  1  ciphertext available.
- `out_data`  out  [0:127]  ciphertext.
- `out_id`  out  1  requester that owns `out_data`.
- `out_ready`  in  1  consumer accept.
- `busy`  out  1  high in ROUND and HOLD.

## Operation
- FSM states: IDLE, ROUND, HOLD.
- **IDLE.**
  - Arbitration is round-robin with pointer `rr`.
  - If only one `req_valid` is high, that requester wins.
  - If both are high, requester `rr` wins.
  - `req_ready[g]` is combinational: 1 only in IDLE for the winner `g`.
  - On an accept edge (`req_valid[g] && req_ready[g]`):
    - `state <= req_data[g] ^ words[0:127]`
    - `round <= 1`
    - `id <= g`
    - `rr <= ~g`
    - go to ROUND.
- **ROUND.**
  - `dp_in = state`
  - `dp_key = words[128·round +: 128]`
  - `dp_final = (round == Nr)`
  - Each edge: `state <= dp_out`.
  - If `round < Nr`: `round <= round+1`.
  - Otherwise go to HOLD.
- **HOLD.**
  - `out_valid = 1`, `out_data = state`, `out_id = id`.
  - On an edge with `out_ready = 1`, go to IDLE.
  - A new request is accepted no earlier than the following cycle.
- Outside ROUND: `dp_in`, `dp_key` and `dp_final` are 0.
- Outside HOLD: `out_data` and `out_id` are 0.
- `round` counter width is 4 bits (maximum Nr = 14).
- `req_valid` is ignored outside IDLE.
- A requester may drop `req_valid` without having been granted; no state is kept for it.

## Timing
- Reset values:
  - Outputs: `req_ready = 0` (internal accept enables are forced low while `reset` is asserted), `out_valid = 0`, `out_data = 0`, `out_id = 0`, `busy = 0`, `dp_* = 0`.
  - Internal: FSM in IDLE, `rr = 0`, `round = 0`, `state = 0`.
- Reset asserted mid-block: the block in flight is discarded with no output; after release the FSM is in IDLE with `rr = 0`.
- Latency: accept edge at cycle T, `out_valid` high from cycle T+Nr until the `out_ready` handshake. This is 10, 12 or 14 cycles for x = 0, 1, 2.
- Throughput with `out_ready` held at 1: one block per Nr+2 cycles.
- `out_valid`, `out_data` and `out_id` are held stable while `out_ready = 0`.
- `dp_out` is sampled at the same edge it is used; the datapath is purely combinational (single-cycle round).

## Structure
- Shared package `aes_pkg` holds:
  - `function nr(x)` returning 10+2·x;
  - the `sched_state_t` enum (IDLE/ROUND/HOLD);
  - `ROUND_W = 4`;
  - `BLK_W = 128`.
- One sub-module: `aes_rr_arbiter`, a 2-way round-robin arbiter.
  - Inputs: `req[0:1]`, `rr`, `en`.
  - Outputs: `gnt[0:1]`, `gnt_id`.
  - It is combinational; the `rr` register lives in the scheduler.
- The round datapath is instantiated next to the scheduler by the bench and the top level, not inside this block.

## Test plan
- **AES-128, x=0.**
  - Setup: real datapath plus expander; key 000102…0f; requester 0 sends 00112233445566778899aabbccddeeff.
  - Expected: `out_data = 69c4e0d86a7b0430d8cdb78070b4c55a`, `out_id = 0`, `out_valid` exactly 10 cycles after the accept edge.
- **AES-256, x=2.**
  - Setup: key 000102…1f; same plaintext.
  - Expected: `out_data = 8ea2b7ca516745bfeafc49904b496089`, latency 14 cycles.
- **Contention.**
  - Setup: both `req_valid` held high, `out_ready = 1`.
  - Expected: grants alternate 0,1,0,1; each `out_id` matches its grant; one block completes per Nr+2 cycles.
- **Backpressure.**
  - Setup: `out_ready = 0` for 5 cycles in HOLD.
  - Expected: `out_valid`/`out_data` stable throughout; `req_ready = 00` during the stall; IDLE follows the handshake edge.
- **Reset mid-block.**
  - Setup: assert `reset` asynchronously at round 4.
  - Expected: all outputs 0 immediately; no `out_valid`; the next request is granted to requester 0 first; its result is correct.
- **Lone requester 1 after a reset.**
  - Setup: only requester 1 is valid.
  - Expected: granted immediately despite `rr = 0`.
